load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the 64-bit data-memory interface; the single master driving the data memory's address, write-data, read and write strobes.
- Accepts load/store requests from the execute stage through a valid/ready handshake and translates byte addresses into doubleword indices.
- Performs sub-word loads with sign or zero extension, and sub-word stores by read-modify-write.
- Returns one response per request, flagging misaligned or out-of-range accesses without touching memory.

Parameters:
DEPTH, 256, number of 64-bit words in the data memory; valid indices are 0..DEPTH-1.

Ports:
clk  input  1  clock; all logic updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and doublewords.
req_addr  input  64  byte address.
req_wdata  input  64  store data, right-aligned in bits [8*2^size-1:0].
resp_valid  output  1  one-cycle response pulse.
resp_rdata  output  64  extended load data; 0 for stores and errors.
resp_error  output  1  qualifies resp_valid; misaligned or out-of-range access.
mem_addr  output  64  doubleword index, equal to req_addr >> 3.
mem_wdata  output  64  full 64-bit word to write.
mem_read  output  1  read strobe; the memory registers read data on this edge.
mem_write  output  1  write strobe.
mem_rdata  input  64  memory read data; valid the cycle after mem_read.

Behaviour:
- States: IDLE, READ, WAIT, WRITE, RESP.
- Reset: state IDLE; resp_valid, resp_error, mem_read and mem_write = 0; resp_rdata, mem_addr and mem_wdata = 0.
  - Reset mid-operation abandons the request; no strobe is asserted in the reset cycle or after it.
  - Memory contents are not reset.
- IDLE: req_ready = 1. On req_valid, the unit captures write, size, unsigned, addr and wdata.
  - Misaligned (addr mod 2^size != 0) or addr>>3 >= DEPTH: go to RESP with error = 1.
  - Doubleword store: go to WRITE.
  - Any other access: go to READ.
- READ: mem_read = 1, mem_addr = index. Next state is WAIT.
- WAIT: mem_rdata is valid.
  - Load: select bytes at offset addr[2:0] (little-endian lanes), extend per size and unsigned, register into resp_rdata, go to RESP.
  - Sub-word store: merge the low 2^size bytes of wdata into the fetched word at that offset, then go to WRITE.
- WRITE: mem_write = 1, mem_addr = index, mem_wdata = merged word (or wdata for doublewords). Next state is RESP.
- RESP: resp_valid = 1 for exactly one cycle. Next state is IDLE; the next request is accepted one cycle later.
- Strobes:
  - mem_read is high only in READ and mem_write only in WRITE; they are never high together.
  - mem_addr and mem_wdata hold their last values outside READ/WRITE.
- Latency in cycles, counted from the acceptance edge to resp_valid:
  - error: 1
  - doubleword store: 2
  - load: 3
  - sub-word store: 4
- Only one request is outstanding at a time. req_valid while req_ready = 0 is ignored and does not need to be held.
- Errors never assert mem_read or mem_write.
- For an unsigned doubleword load, req_unsigned has no effect.

Test Plan:
- Store doubleword 0x1122334455667788 at addr 0x10 -> mem_write high for one cycle with mem_addr = 2; then load doubleword from 0x10 -> resp_rdata = 0x1122334455667788 three cycles after acceptance.
- Signed byte load at 0x17 with word 2 = 0x80FF..: resp_rdata = 0xFFFFFFFFFFFFFF80. The same access with req_unsigned = 1 -> 0x0000000000000080.
- Half store 0xBEEF at 0x12 over 0x1122334455667788 -> memory word 2 becomes 0x11223344BEEF7788; exactly one read followed by one write; response at cycle 4.
- Word load at 0x0A -> resp_error = 1 and resp_rdata = 0 at cycle 1, with no strobes. Byte load at 0x800 (index 256, DEPTH = 256) -> error.
- Reset asserted during WAIT of a sub-word store -> no mem_write occurs; state IDLE with req_ready = 1 the cycle after reset deasserts; memory word unchanged.
- Back-to-back req_valid held high for two loads -> the second is accepted only after RESP; resp_valid pulses exactly twice, one cycle each.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit: execute-side request/response and the
// data-memory initiator port.

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

interface lsu_mem_if;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );
    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: single initiator of the 64-bit data memory. Sub-word loads are
// extracted and extended; sub-word stores are done as read-modify-write.

module lsu_byte_lane #(
    parameter int LANE = 0
) (
    input  logic [2:0] off,
    input  logic [1:0] size,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    localparam logic [3:0] L = 4'(LANE);

    logic [3:0] lo, hi;

    // Lane takes store data when it falls inside [off, off + 2^size).
    assign lo     = {1'b0, off};
    assign hi     = lo + (4'd1 << size);
    assign merged = (L >= lo && L < hi) ? new_byte : old_byte;
endmodule

module load_store_unit #(
    parameter int DEPTH = 256
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    localparam int NUM_LANES = 8;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  off;
        logic [63:0] wdata;
    } req_t;

    state_t      state;
    req_t        cur;
    logic        ready_q, resp_valid_q, resp_error_q, rd_q, wr_q;
    logic [63:0] rdata_q, addr_q, wdata_q;

    logic [63:0] idx;
    logic        misaligned, out_of_range;
    logic [63:0] rd_sh, load_val;
    logic [NUM_LANES-1:0][7:0] rd_lanes, wr_lanes, merged;

    assign idx          = req.req_addr >> 3;
    assign out_of_range = idx >= 64'(DEPTH);

    always_comb begin
        misaligned = 1'b0;
        case (req.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req.req_addr[0];
            2'd2:    misaligned = |req.req_addr[1:0];
            default: misaligned = |req.req_addr[2:0];
        endcase
    end

    // Load path: bring the addressed lanes down to bit 0, then extend.
    assign rd_sh = mem.mem_rdata >> {cur.off, 3'b000};

    always_comb begin
        load_val = rd_sh;
        case (cur.size)
            2'd0:    load_val = {{56{~cur.uns & rd_sh[7]}},  rd_sh[7:0]};
            2'd1:    load_val = {{48{~cur.uns & rd_sh[15]}}, rd_sh[15:0]};
            2'd2:    load_val = {{32{~cur.uns & rd_sh[31]}}, rd_sh[31:0]};
            default: load_val = rd_sh;
        endcase
    end

    // Store path: align store data to its lanes and merge over the fetched word.
    assign rd_lanes = mem.mem_rdata;
    assign wr_lanes = cur.wdata << {cur.off, 3'b000};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lsu_byte_lane #(.LANE(i)) u_lane (
            .off      (cur.off),
            .size     (cur.size),
            .old_byte (rd_lanes[i]),
            .new_byte (wr_lanes[i]),
            .merged   (merged[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cur          <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        cur <= '{write: req.req_write, size: req.req_size,
                                 uns: req.req_unsigned, off: req.req_addr[2:0],
                                 wdata: req.req_wdata};
                        ready_q <= 1'b0;
                        rdata_q <= '0;
                        if (misaligned || out_of_range) begin
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            state        <= RESP;
                        end else if (req.req_write && req.req_size == 2'd3) begin
                            wr_q    <= 1'b1;
                            addr_q  <= idx;
                            wdata_q <= req.req_wdata;
                            state   <= WRITE;
                        end else begin
                            rd_q   <= 1'b1;
                            addr_q <= idx;
                            state  <= READ;
                        end
                    end
                end
                READ: begin
                    rd_q  <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cur.write) begin
                        wr_q    <= 1'b1;
                        wdata_q <= merged;
                        state   <= WRITE;
                    end else begin
                        rdata_q      <= load_val;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                WRITE: begin
                    wr_q         <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_error_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req.req_ready  = ready_q;
    assign req.resp_valid = resp_valid_q;
    assign req.resp_rdata = rdata_q;
    assign req.resp_error = resp_error_q;

    // Strobes are masked while reset is held so an abandoned access never fires.
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_read  = rd_q & ~reset;
    assign mem.mem_write = wr_q & ~reset;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a registered-read memory model.

module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;

    lsu_req_if rq();
    lsu_mem_if mi();

    load_store_unit #(.DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (rq),
        .mem   (mi)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [256];
    logic [63:0] mrdata;

    always @(posedge clk) begin
        if (mi.mem_read)  mrdata <= mem[mi.mem_addr[7:0]];
        if (mi.mem_write) mem[mi.mem_addr[7:0]] <= mi.mem_wdata;
    end
    assign mi.mem_rdata = mrdata;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic        chk_mem;
        int          midx;
        logic [63:0] mval;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;
    int nwr_rst, pulses, acc, acc_cyc[2];
    logic prev_rv, dbl;

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [63:0] a, input logic [63:0] wd,
                                input logic [63:0] rd, input logic e, input int lat,
                                input int nrd, input int nwr, input logic cm,
                                input int midx, input logic [63:0] mv);
        vec_t v;
        v.write = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.err = e; v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.chk_mem = cm;
        v.midx = midx; v.mval = mv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd);
        rq.req_write = w; rq.req_size = sz; rq.req_unsigned = u;
        rq.req_addr = a; rq.req_wdata = wd;
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
    task automatic run_req(input int n, input vec_t v);
        int lat, nrd, nwr;
        logic got;
        logic [63:0] waddr, rdata;
        logic err;
        lat = 0; nrd = 0; nwr = 0; got = 1'b0; waddr = '0; rdata = '0; err = 1'b0;
        chk($sformatf("v%0d ready", n), 64'(rq.req_ready), 64'd1);
        drive(v.write, v.size, v.uns, v.addr, v.wdata);
        rq.req_valid = 1'b1;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (mi.mem_read) nrd++;
            if (mi.mem_write) begin nwr++; waddr = mi.mem_addr; end
            if (mi.mem_read && mi.mem_write) chk($sformatf("v%0d strobes overlap", n), 64'd1, 64'd0);
            if (rq.resp_valid) begin
                got = 1'b1; lat = c; rdata = rq.resp_rdata; err = rq.resp_error;
            end
        end
        chk($sformatf("v%0d latency", n), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d rdata", n), rdata, v.rdata);
        chk($sformatf("v%0d error", n), 64'(err), 64'(v.err));
        chk($sformatf("v%0d reads", n), 64'(nrd), 64'(v.nrd));
        chk($sformatf("v%0d writes", n), 64'(nwr), 64'(v.nwr));
        if (v.nwr > 0) chk($sformatf("v%0d write addr", n), waddr, v.addr >> 3);
        @(negedge clk);
        chk($sformatf("v%0d resp one cycle", n), 64'(rq.resp_valid), 64'd0);
        if (v.chk_mem) chk($sformatf("v%0d mem word", n), mem[v.midx], v.mval);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[4]   = 64'h0102030405060708;
        mem[255] = 64'hAB00000000000000;
        rq.req_valid = 1'b0;
        drive(1'b0, 2'd0, 1'b0, '0, '0);
        reset = 1'b1;

        //            w     sz    u     addr       wdata                   rdata                   e  lat rd wr cm idx mval
        tbl.push_back(mk(1, 2'd3, 0, 64'h10,  64'h1122334455667788, 64'h0,                  0, 2, 0, 1, 1, 2, 64'h1122334455667788));
        tbl.push_back(mk(0, 2'd3, 0, 64'h10,  64'h0,                64'h1122334455667788, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 2'd1, 0, 64'h12,  64'hFFFFFFFFFFFFBEEF, 64'h0,                  0, 4, 1, 1, 1, 2, 64'h11223344BEEF7788));
        tbl.push_back(mk(0, 2'd3, 0, 64'h10,  64'h0,                64'h11223344BEEF7788, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 2'd3, 0, 64'h10,  64'h80FF000012345678, 64'h0,                  0, 2, 0, 1, 1, 2, 64'h80FF000012345678));
        tbl.push_back(mk(0, 2'd0, 0, 64'h17,  64'h0,                64'hFFFFFFFFFFFFFF80, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd0, 1, 64'h17,  64'h0,                64'h0000000000000080, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd1, 0, 64'h16,  64'h0,                64'hFFFFFFFFFFFF80FF, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd2, 1, 64'h14,  64'h0,                64'h0000000080FF0000, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd2, 0, 64'h10,  64'h0,                64'h0000000012345678, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 2'd0, 0, 64'h13,  64'h00000000000000A5, 64'h0,                  0, 4, 1, 1, 1, 2, 64'h80FF0000A5345678));
        tbl.push_back(mk(1, 2'd2, 0, 64'h14,  64'h00000000CAFEF00D, 64'h0,                  0, 4, 1, 1, 1, 2, 64'hCAFEF00DA5345678));
        tbl.push_back(mk(0, 2'd2, 0, 64'h14,  64'h0,                64'hFFFFFFFFCAFEF00D, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd3, 1, 64'h10,  64'h0,                64'hCAFEF00DA5345678, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd2, 0, 64'h0A,  64'h0,                64'h0,                  1, 1, 0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd0, 0, 64'h800, 64'h0,                64'h0,                  1, 1, 0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd0, 1, 64'h7FF, 64'h0,                64'h00000000000000AB, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 2'd3, 0, 64'h14,  64'hDEAD,             64'h0,                  1, 1, 0, 0, 1, 2, 64'hCAFEF00DA5345678));
        tbl.push_back(mk(0, 2'd1, 0, 64'h11,  64'h0,                64'h0,                  1, 1, 0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd1, 0, 64'h7FE, 64'h0,                64'hFFFFFFFFFFFFAB00, 0, 3, 1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 2'd0, 0, 64'h800, 64'h55,               64'h0,                  1, 1, 0, 0, 1, 255, 64'hAB00000000000000));

        repeat (3) @(negedge clk);
        chk("rst ready", 64'(rq.req_ready), 64'd1);
        chk("rst resp_valid", 64'(rq.resp_valid), 64'd0);
        chk("rst resp_error", 64'(rq.resp_error), 64'd0);
        chk("rst resp_rdata", rq.resp_rdata, 64'd0);
        chk("rst mem_read", 64'(mi.mem_read), 64'd0);
        chk("rst mem_write", 64'(mi.mem_write), 64'd0);
        chk("rst mem_addr", mi.mem_addr, 64'd0);
        chk("rst mem_wdata", mi.mem_wdata, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) run_req(i, tbl[i]);

        // Reset during WAIT of a byte store must abandon the write.
        nwr_rst = 0;
        drive(1'b1, 2'd0, 1'b0, 64'h20, 64'h77);
        rq.req_valid = 1'b1;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        @(negedge clk);
        chk("rmw read strobe", 64'(mi.mem_read), 64'd1);
        if (mi.mem_write) nwr_rst++;
        @(negedge clk);
        if (mi.mem_write) nwr_rst++;
        reset = 1'b1;
        @(negedge clk);
        chk("rst-cycle mem_write", 64'(mi.mem_write), 64'd0);
        chk("rst-cycle mem_read", 64'(mi.mem_read), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst ready", 64'(rq.req_ready), 64'd1);
        chk("post-rst resp_valid", 64'(rq.resp_valid), 64'd0);
        repeat (4) begin
            @(negedge clk);
            if (mi.mem_write) nwr_rst++;
        end
        chk("abandoned writes", 64'(nwr_rst), 64'd0);
        chk("abandoned mem word", mem[4], 64'h0102030405060708);

        // Two loads with req_valid held: second accepted only after RESP.
        pulses = 0; acc = 0; prev_rv = 1'b0; dbl = 1'b0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        drive(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) rq.req_valid = 1'b1;
            if (acc == 2) rq.req_valid = 1'b0;
            if (rq.resp_valid) begin
                pulses++;
                if (prev_rv) dbl = 1'b1;
                chk($sformatf("b2b rdata %0d", pulses), rq.resp_rdata, 64'hCAFEF00DA5345678);
            end
            prev_rv = rq.resp_valid;
            if (rq.req_ready && rq.req_valid) begin
                if (acc < 2) acc_cyc[acc] = c;
                acc++;
            end
        end
        rq.req_valid = 1'b0;
        chk("b2b accepts", 64'(acc), 64'd2);
        chk("b2b spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
        chk("b2b pulses", 64'(pulses), 64'd2);
        chk("b2b pulse width", 64'(dbl), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
